// File: rtl/dft_16to8_ctrl.sv
// dft_16to8_ctrl: frame sequencer for the dft_16to8 radix stage.
//
// Deserialises 32 real input samples into the fa/fb operand banks, latches
// the twiddle set, waits SETTLE_CYC cycles for the combinational datapath,
// snapshots the 32 complex results and streams them out with valid/ready.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, abort       frame start (IDLE only), synchronous abort (any state)
//   cfg_tw_set/tw_set  twiddle set in / latched twiddle set to ROM
//   in_valid/in_ready/in_data       serial sample input
//   fa_bus, fb_bus     operand banks, element 0 at the LSBs
//   res_bus            datapath results, slot k = {imag, real}, real at LSBs
//   out_valid/out_ready/out_r/out_i/out_idx/out_last   serial result output
//   busy, done         state != IDLE, one-cycle pulse after the last result
//   frame_cnt          completed-frame counter (only with DFT_CTRL_FRMCNT_EN)
//
// Optional feature macro: DFT_CTRL_FRMCNT_EN

module dft_16to8_ctrl #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int TWS_W      = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TWS_W-1:0]     cfg_tw_set,
    output logic [TWS_W-1:0]     tw_set,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    output logic [16*IN_W-1:0]   fa_bus,
    output logic [16*IN_W-1:0]   fb_bus,
    input  logic [64*OUT_W-1:0]  res_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_r,
    output logic [OUT_W-1:0]     out_i,
    output logic [4:0]           out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
`ifdef DFT_CTRL_FRMCNT_EN
    ,
    output logic [15:0]          frame_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_t               state_q, state_d;
    logic [4:0]           beat_q, beat_d;
    logic [3:0]           settle_q, settle_d;
    logic [4:0]           idx_q, idx_d;
    logic [TWS_W-1:0]     tw_q, tw_d;
    logic [16*IN_W-1:0]   fa_q, fa_d;
    logic [16*IN_W-1:0]   fb_q, fb_d;
    logic [64*OUT_W-1:0]  snap_q, snap_d;
    logic                 pend_q, pend_d;
    logic                 done_q, done_d;
    logic [64*OUT_W-1:0]  snap_src;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        tw_d     = tw_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        snap_d   = snap_q;
        pend_d   = pend_q;
        done_d   = 1'b0;

        if (abort) begin
            state_d  = IDLE;
            beat_d   = '0;
            settle_d = '0;
            idx_d    = '0;
            pend_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The done cycle still belongs to the finishing frame, so a
                    // start coinciding with done is dropped.
                    if (start && !done_q) begin
                        tw_d    = cfg_tw_set;
                        beat_d  = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (!beat_q[4]) begin
                            fa_d[int'(beat_q[3:0])*IN_W +: IN_W] = in_data;
                        end else begin
                            fb_d[int'(beat_q[3:0])*IN_W +: IN_W] = in_data;
                        end
                        beat_d = beat_q + 5'd1;
                        if (beat_q == 5'd31) begin
                            beat_d   = '0;
                            settle_d = '0;
                            idx_d    = '0;
                            if (SETTLE_CYC == 0) begin
                                // No settle phase: snapshot is taken during the
                                // first DRAIN cycle; res_bus is bypassed until then.
                                state_d = DRAIN;
                                pend_d  = 1'b1;
                            end else begin
                                state_d = SETTLE;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        snap_d   = res_bus;
                        settle_d = '0;
                        idx_d    = '0;
                        state_d  = DRAIN;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (pend_q) begin
                        snap_d = res_bus;
                        pend_d = 1'b0;
                    end
                    if (out_ready) begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd31) begin
                            idx_d   = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            tw_q     <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            snap_q   <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            tw_q     <= tw_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            snap_q   <= snap_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
        end
    end

`ifdef DFT_CTRL_FRMCNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (done_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign snap_src  = pend_q ? res_bus : snap_q;

    assign tw_set    = tw_q;
    assign fa_bus    = fa_q;
    assign fb_bus    = fb_q;
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_r     = snap_src[int'(idx_q)*2*OUT_W +: OUT_W];
    assign out_i     = snap_src[int'(idx_q)*2*OUT_W + OUT_W +: OUT_W];
    assign out_idx   = idx_q;
    assign out_last  = (state_q == DRAIN) && (idx_q == 5'd31);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_dft_16to8_ctrl.sv
// Directed testbench for dft_16to8_ctrl (default parameters, SETTLE_CYC=2).
module tb_dft_16to8_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [2:0]   cfg_tw_set;
    logic [2:0]   tw_set;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [127:0] fa_bus;
    logic [127:0] fb_bus;
    logic [511:0] res_bus;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_r;
    logic [7:0]   out_i;
    logic [4:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         done;
`ifdef DFT_CTRL_FRMCNT_EN
    logic [15:0]  frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int res_ofs  = 0;

    dft_16to8_ctrl #(
        .IN_W(8),
        .OUT_W(8),
        .TWS_W(3),
        .SETTLE_CYC(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .cfg_tw_set(cfg_tw_set),
        .tw_set(tw_set),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .fa_bus(fa_bus),
        .fb_bus(fb_bus),
        .res_bus(res_bus),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r(out_r),
        .out_i(out_i),
        .out_idx(out_idx),
        .out_last(out_last),
        .busy(busy),
        .done(done)
`ifdef DFT_CTRL_FRMCNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: slot k = {imag = -(k+ofs), real = k+ofs}.
    always_comb begin
        res_bus = '0;
        for (int k = 0; k < 32; k++) begin
            res_bus[k*16 +: 8]     = 8'(k + res_ofs);
            res_bus[k*16 + 8 +: 8] = 8'(0 - (k + res_ofs));
        end
    end

    task automatic do_start(input logic [2:0] tws);
        start      = 1'b1;
        cfg_tw_set = tws;
        @(negedge clk);
        start      = 1'b0;
        cfg_tw_set = 3'd0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
        n_checks++;
        if (tw_set !== tws) begin n_fail++; $display("FAIL tw_set: got %0d want %0d", tw_set, tws); end
    endtask

    // Loads 32 beats of base+k; optional gap of gap_len idle cycles after beat gap_at.
    task automatic load_frame(input int base, input int gap_at, input int gap_len);
        res_ofs = 0;
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_load beat %0d: got %b want 1", k, in_ready); end
            in_valid = 1'b1;
            in_data  = 8'(base + k);
            @(negedge clk);
            in_valid = 1'b0;
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    n_checks++;
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                        n_fail++; $display("FAIL gap_state cyc %0d: in_ready=%b out_valid=%b want 1/0", g, in_ready, out_valid);
                    end
                end
            end
        end
    endtask

    task automatic check_banks(input int base);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (fa_bus[k*8 +: 8] !== 8'(base + k)) begin
                n_fail++; $display("FAIL fa%0d: got %0d want %0d", k, fa_bus[k*8 +: 8], 8'(base + k));
            end
            n_checks++;
            if (fb_bus[k*8 +: 8] !== 8'(base + 16 + k)) begin
                n_fail++; $display("FAIL fb%0d: got %0d want %0d", k, fb_bus[k*8 +: 8], 8'(base + 16 + k));
            end
        end
    endtask

    // Called at the negedge right after beat 31; expects out_valid 3 cycles after the beat.
    task automatic wait_valid();
        int lat = 1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL in_ready_drop: got %b want 0", in_ready); end
        // No-hold upstream: keep junk valid while in_ready is low.
        in_valid = 1'b1;
        in_data  = 8'hEE;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL latency: got %0d want 3", lat); end
    endtask

    // Drains 32 results; stall selects the 1,0,0,1 out_ready pattern.
    task automatic drain(input bit stall);
        int exp_idx = 0;
        int cyc = 0;
        logic rdy;
        while (exp_idx < 32 && cyc < 200) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 5'(exp_idx) || out_r !== 8'(exp_idx) ||
                out_i !== 8'(0 - exp_idx) || out_last !== (exp_idx == 31) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL drain idx %0d: v=%b idx=%0d r=%0d i=%0d last=%b done=%b want v=1 idx=%0d r=%0d i=%0d last=%b done=0",
                         exp_idx, out_valid, out_idx, out_r, out_i, out_last, done,
                         exp_idx, 8'(exp_idx), 8'(0 - exp_idx), (exp_idx == 31));
            end
            res_ofs   = 77;   // results must now come from the snapshot
            rdy       = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) exp_idx++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse: done=%b valid=%b busy=%b want 1/0/0", done, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_tw_set = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
            tw_set !== 3'd0 || fa_bus !== '0 || fb_bus !== '0 || out_r !== 8'd0 ||
            out_i !== 8'd0 || out_idx !== 5'd0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: busy=%b rdy=%b v=%b done=%b tw=%0d r=%0d i=%0d idx=%0d want all 0",
                               busy, in_ready, out_valid, done, tw_set, out_r, out_i, out_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_start(3'd3);
        load_frame(1, -1, 0);
        wait_valid();
        check_banks(1);
        drain(1'b0);
`ifdef DFT_CTRL_FRMCNT_EN
        n_checks++;
        if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL frame_cnt_basic: got %0d want 1", frame_cnt); end
`endif
        // start during the done cycle is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done: done=%b busy=%b want 0/0", done, busy); end
        n_checks++;
        if (tw_set !== 3'd3) begin n_fail++; $display("FAIL tw_set_hold: got %0d want 3", tw_set); end
    endtask

    task automatic test_backpressure_gaps();
        do_start(3'd5);
        load_frame(100, 10, 5);
        wait_valid();
        check_banks(100);
        drain(1'b1);
        @(negedge clk);
    endtask

    task automatic test_abort();
        do_start(3'd6);
        res_ofs = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(50 + k);
            @(negedge clk);
        end
        in_data = 8'(70);
        abort   = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: busy=%b rdy=%b v=%b want 0/0/0", busy, in_ready, out_valid);
        end
        n_checks++;
        if (fb_bus[4*8 +: 8] !== 8'd120 || fa_bus[0 +: 8] !== 8'd50 || fb_bus[3*8 +: 8] !== 8'd69) begin
            n_fail++; $display("FAIL abort_banks: fb4=%0d fa0=%0d fb3=%0d want 120/50/69",
                               fb_bus[4*8 +: 8], fa_bus[0 +: 8], fb_bus[3*8 +: 8]);
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done cyc %0d: got %b want 0", c, done); end
            @(negedge clk);
        end
`ifdef DFT_CTRL_FRMCNT_EN
        n_checks++;
        if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL frame_cnt_abort: got %0d want 2", frame_cnt); end
`endif
        do_start(3'd2);
        load_frame(200, -1, 0);
        wait_valid();
        check_banks(200);
        drain(1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_drain();
        do_start(3'd7);
        load_frame(10, -1, 0);
        wait_valid();
        for (int k = 0; k < 12; k++) begin
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_idx !== 5'd12 || out_r !== 8'd12) begin
            n_fail++; $display("FAIL pre_reset_idx: idx=%0d r=%0d want 12/12", out_idx, out_r);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_idx !== 5'd0 || out_r !== 8'd0 || out_i !== 8'd0 ||
            busy !== 1'b0 || tw_set !== 3'd0 || fa_bus !== '0 || fb_bus !== '0) begin
            n_fail++; $display("FAIL async_reset: v=%b idx=%0d r=%0d i=%0d busy=%b tw=%0d want all 0",
                               out_valid, out_idx, out_r, out_i, busy, tw_set);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(3'd4);
        load_frame(30, -1, 0);
        wait_valid();
        check_banks(30);
        drain(1'b0);
`ifdef DFT_CTRL_FRMCNT_EN
        n_checks++;
        if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL frame_cnt_after_reset: got %0d want 1", frame_cnt); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure_gaps();
        test_abort();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
